// File: rtl/multi_osc_pkg.sv
// Shared definitions for the multi-channel oscillator sequencer:
// send-FSM state type, MAX5134 write command and channel-select helper.
package multi_osc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        ACK,
        WAIT
    } seq_state_e;

    // MAX5134 "write and update" command; low nibble selects DAC channel A..D
    localparam logic [7:0] DAC_CMD_WRITE = 8'b0011_0000;

    // Command byte addressing DAC channel ch (0 -> A, 1 -> B, ...)
    function automatic logic [7:0] dac_chan_cmd(input logic [1:0] ch);
        return DAC_CMD_WRITE | (8'd1 << ch);
    endfunction

endpackage

// File: rtl/phase_accumulator.sv
// One oscillator channel: double-buffered frequency (pending -> active on
// tick), clamped frequency writes and a modular phase accumulator whose
// pre-update value is latched into a send buffer at every tick.
// With MULTI_OSC_ERR_EN defined the post-copy active frequency is exported
// for the bad-frequency comparator in the top level.
module phase_accumulator #(
    parameter int unsigned PHASE_WIDTH = 16,
    parameter int unsigned PHASE_LIMIT = 44000
) (
    input  logic                   clock_in,
    input  logic                   reset,
    input  logic                   wr_i,
    input  logic [PHASE_WIDTH-1:0] data_i,
    input  logic                   tick_i,
`ifdef MULTI_OSC_ERR_EN
    output logic [PHASE_WIDTH-1:0] active_next_o,
`endif
    output logic [PHASE_WIDTH-1:0] phase_buf_o
);

    localparam logic [PHASE_WIDTH-1:0] LIMIT   = PHASE_WIDTH'(PHASE_LIMIT);
    localparam logic [PHASE_WIDTH:0]   LIMIT_X = (PHASE_WIDTH + 1)'(PHASE_LIMIT);

    logic [PHASE_WIDTH-1:0] pending_q, pending_d;
    logic [PHASE_WIDTH-1:0] active_q,  active_d;
    logic [PHASE_WIDTH-1:0] phase_q,   phase_d;
    logic [PHASE_WIDTH-1:0] buf_q,     buf_d;
    logic [PHASE_WIDTH:0]   sum;

    // Next-state: clamped write into pending, copy to active and advance phase on tick
    always_comb begin
        pending_d = pending_q;
        if (wr_i) begin
            pending_d = (data_i >= LIMIT) ? LIMIT - 1'b1 : data_i;
        end

        // The phase step uses the frequency that becomes active on this tick,
        // so a write shows up in the sent phase two ticks later.
        active_d = tick_i ? pending_q : active_q;
        sum      = {1'b0, phase_q} + {1'b0, active_d};

        phase_d = phase_q;
        buf_d   = buf_q;
        if (tick_i) begin
            buf_d   = phase_q;
            phase_d = (sum >= LIMIT_X) ? PHASE_WIDTH'(sum - LIMIT_X) : sum[PHASE_WIDTH-1:0];
        end
    end

    // Channel state registers
    always_ff @(posedge clock_in) begin
        if (reset) begin
            pending_q <= '0;
            active_q  <= '0;
            phase_q   <= '0;
            buf_q     <= '0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            phase_q   <= phase_d;
            buf_q     <= buf_d;
        end
    end

    assign phase_buf_o = buf_q;

`ifdef MULTI_OSC_ERR_EN
    assign active_next_o = active_d;
`endif

endmodule

// File: rtl/multi_osc_sequencer.sv
// Multi-channel phase-accumulator oscillator core. A common sample tick
// advances every channel; afterwards one 24-bit MAX5134 command word per
// channel is streamed to the DAC SPI block, handshaking on dac_busy.
// Optional feature macro: MULTI_OSC_ERR_EN builds the per-channel
// ERR_THRESHOLD comparators behind err_out (tied to 0 otherwise).
module multi_osc_sequencer
    import multi_osc_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS    = 2,
    parameter int unsigned PHASE_WIDTH     = 16,
    parameter int unsigned PHASE_LIMIT     = 44000,
    parameter int unsigned SAMPLE_INTERVAL = 2015,
    parameter int unsigned ERR_THRESHOLD   = 1000
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic                    freq_wr,
    input  logic [1:0]              freq_chan,
    input  logic [PHASE_WIDTH-1:0]  freq_data,
    output logic [23:0]             dac_data,
    output logic                    dac_send,
    input  logic                    dac_busy,
    output logic                    sample_tick,
    output logic                    overrun,
    output logic [NUM_CHANNELS-1:0] err_out
);

    localparam int unsigned CNT_W   = (SAMPLE_INTERVAL > 0) ? $clog2(SAMPLE_INTERVAL + 1) : 1;
    localparam logic [1:0]  LAST_CH = 2'(NUM_CHANNELS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    seq_state_e       state_q;
    logic [1:0]       ch_q;
    logic [23:0]      dac_data_q;
    logic             dac_send_q;
    logic             overrun_q;

    logic [PHASE_WIDTH-1:0] buf_w [NUM_CHANNELS];
    logic [PHASE_WIDTH-1:0] sel_phase;
`ifdef MULTI_OSC_ERR_EN
    logic [PHASE_WIDTH-1:0] active_next_w [NUM_CHANNELS];
`endif

    assign tick = (cnt_q == CNT_W'(SAMPLE_INTERVAL));

    // Tick counter next value: wrap to 0 after the tick cycle
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Tick counter register
    always_ff @(posedge clock_in) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Per-channel accumulators; writes to channels beyond NUM_CHANNELS decode to nothing
    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
        logic wr_k;
        assign wr_k = freq_wr && (freq_chan == 2'(k));

        phase_accumulator #(
            .PHASE_WIDTH (PHASE_WIDTH),
            .PHASE_LIMIT (PHASE_LIMIT)
        ) u_acc (
            .clock_in      (clock_in),
            .reset         (reset),
            .wr_i          (wr_k),
            .data_i        (freq_data),
            .tick_i        (tick),
`ifdef MULTI_OSC_ERR_EN
            .active_next_o (active_next_w[k]),
`endif
            .phase_buf_o   (buf_w[k])
        );
    end

    // Select the send buffer of the channel currently being streamed
    always_comb begin
        sel_phase = '0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            if (ch_q == 2'(k)) begin
                sel_phase = buf_w[k];
            end
        end
    end

    // Send FSM: per channel LOAD -> SEND -> ACK -> WAIT(busy), overrun on tick outside IDLE
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            dac_data_q <= '0;
            dac_send_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            dac_send_q <= 1'b0;
            if (tick && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        ch_q    <= '0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    dac_data_q <= {dac_chan_cmd(ch_q), 16'(sel_phase)};
                    dac_send_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    state_q <= ACK;
                end
                ACK: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (!dac_busy) begin
                        if (ch_q == LAST_CH) begin
                            state_q <= IDLE;
                        end else begin
                            ch_q    <= ch_q + 1'b1;
                            state_q <= LOAD;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dac_data    = dac_data_q;
    assign dac_send    = dac_send_q;
    assign sample_tick = tick;
    assign overrun     = overrun_q;

`ifdef MULTI_OSC_ERR_EN
    logic [NUM_CHANNELS-1:0] err_q;

    // Bad-frequency flags, re-evaluated against the newly active frequency at each tick
    always_ff @(posedge clock_in) begin
        if (reset) begin
            err_q <= '0;
        end else if (tick) begin
            for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
                err_q[k] <= (active_next_w[k] > PHASE_WIDTH'(ERR_THRESHOLD));
            end
        end
    end

    assign err_out = err_q;
`else
    assign err_out = '0;
`endif

endmodule

// File: tb/tb_multi_osc_sequencer.sv
// Self-checking bench for multi_osc_sequencer: a cycle-level behavioural
// model (modular phase arithmetic, queue of pending channel sends, protocol
// latencies) compared every cycle, plus literal expectations from the test plan.
module tb_multi_osc_sequencer;

    localparam int N     = 2;
    localparam int LIMIT = 44000;
    localparam int SI    = 2015;
    localparam int THR   = 1000;

    logic          clock_in  = 1'b0;
    logic          reset     = 1'b1;
    logic          freq_wr   = 1'b0;
    logic [1:0]    freq_chan = 2'd0;
    logic [15:0]   freq_data = 16'd0;
    logic          dac_busy  = 1'b0;
    logic [23:0]   dac_data;
    logic          dac_send;
    logic          sample_tick;
    logic          overrun;
    logic [N-1:0]  err_out;

    multi_osc_sequencer #(
        .NUM_CHANNELS    (N),
        .PHASE_WIDTH     (16),
        .PHASE_LIMIT     (LIMIT),
        .SAMPLE_INTERVAL (SI),
        .ERR_THRESHOLD   (THR)
    ) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .freq_wr     (freq_wr),
        .freq_chan   (freq_chan),
        .freq_data   (freq_data),
        .dac_data    (dac_data),
        .dac_send    (dac_send),
        .dac_busy    (dac_busy),
        .sample_tick (sample_tick),
        .overrun     (overrun),
        .err_out     (err_out)
    );

    always #5 clock_in = ~clock_in;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          m_valid = 0;
    int          m_cnt;
    int          m_pend  [N];
    int          m_act   [N];
    int          m_phase [N];
    int          m_buf   [N];
    int          q[$];
    int          m_send_at = -1;
    int          m_wait_from = -1;
    logic [23:0] m_data;
    bit          m_ovr;
    logic [N-1:0] m_err;

    // observation logs used by the literal checks
    int          log0[$];
    int          log1[$];
    int          words[$];
    int          n_sends = 0;
    int          last_tick = 0, prev_tick = 0, last_send = 0;

    always @(negedge clock_in) begin
        int ch;
        cyc++;
        if (m_valid) begin
            check("sample_tick", sample_tick, m_cnt == SI);
            check("dac_send", dac_send, cyc == m_send_at);
            if (cyc == m_send_at) begin
                ch          = q.pop_front();
                m_data      = {8'h30 | (8'd1 << ch), 16'(m_buf[ch])};
                m_send_at   = -1;
                m_wait_from = (q.size() > 0) ? cyc + 2 : -1;
            end
            check("dac_data", dac_data, m_data);
            check("overrun", overrun, m_ovr);
            check("err_out", err_out, m_err);
            if (m_wait_from >= 0 && cyc >= m_wait_from && !dac_busy) begin
                m_send_at   = cyc + 2;
                m_wait_from = -1;
            end
            if (sample_tick === 1'b1) begin
                prev_tick = last_tick;
                last_tick = cyc;
            end
            if (dac_send === 1'b1) begin
                last_send = cyc;
                n_sends++;
                words.push_back(int'(dac_data));
                if (dac_data[23:16] == 8'h31) log0.push_back(int'(dac_data[15:0]));
                else if (dac_data[23:16] == 8'h32) log1.push_back(int'(dac_data[15:0]));
            end
        end
        // advance model across the coming rising edge
        if (reset) begin
            m_valid     = 1;
            m_cnt       = 0;
            for (int k = 0; k < N; k++) begin
                m_pend[k] = 0; m_act[k] = 0; m_phase[k] = 0; m_buf[k] = 0;
            end
            q.delete();
            m_send_at   = -1;
            m_wait_from = -1;
            m_data      = '0;
            m_ovr       = 0;
            m_err       = '0;
        end else if (m_valid) begin
            if (m_cnt == SI) begin
                for (int k = 0; k < N; k++) begin
                    m_buf[k]   = m_phase[k];
                    m_act[k]   = m_pend[k];
                    m_phase[k] = (m_phase[k] + m_act[k]) % LIMIT;
`ifdef MULTI_OSC_ERR_EN
                    m_err[k]   = (m_act[k] > THR);
`endif
                end
                if (q.size() > 0 || m_wait_from >= 0 || m_send_at >= 0) begin
                    m_ovr = 1;
                end else begin
                    for (int k = 0; k < N; k++) q.push_back(k);
                    m_send_at = cyc + 2;
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            if (freq_wr && int'(freq_chan) < N)
                m_pend[freq_chan] = (int'(freq_data) >= LIMIT) ? LIMIT - 1 : int'(freq_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    task automatic wr(input int ch, input int data);
        freq_wr   = 1'b1;
        freq_chan = 2'(ch);
        freq_data = 16'(data);
        step(1);
        freq_wr   = 1'b0;
    endtask

    task automatic wait_tick();
        int t = 0;
        while (sample_tick !== 1'b1 && t < 2100) begin
            step(1);
            t++;
        end
        if (sample_tick !== 1'b1) check("tick_timeout", sample_tick, 1);
        step(1);
    endtask

    task automatic wait_send();
        int t = 0;
        while (dac_send !== 1'b1 && t < 4000) begin
            step(1);
            t++;
        end
        if (dac_send !== 1'b1) check("send_timeout", dac_send, 1);
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        words.delete();
        n_sends = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        int n0;
        int tick_at;
        step(3);
        reset = 1'b0;
        check("reset_dac_data", dac_data, 24'h0);
        check("reset_overrun", overrun, 0);
        clear_logs();

        // all frequencies zero, busy low: three ticks
        repeat (3) wait_tick();
        step(20);
        check("tick_spacing", last_tick - prev_tick, 2016);
        check("idle_send_count", n_sends, 6);
        check("word0", words.size() > 0 ? words[0] : -1, 32'h310000);
        check("word1", words.size() > 1 ? words[1] : -1, 32'h320000);

        // ch0 = 1000, ch1 = 30000, write to nonexistent ch2 ignored
        clear_logs();
        wr(0, 1000);
        wr(1, 30000);
        wr(2, 500);
        repeat (3) wait_tick();
        step(20);
        check("ch0_cnt", log0.size(), 3);
        check("ch0_s0", log0.size() > 0 ? log0[0] : -1, 0);
        check("ch0_s1", log0.size() > 1 ? log0[1] : -1, 1000);
        check("ch0_s2", log0.size() > 2 ? log0[2] : -1, 2000);
        check("ch1_s0", log1.size() > 0 ? log1[0] : -1, 0);
        check("ch1_s1", log1.size() > 1 ? log1[1] : -1, 30000);
        check("ch1_s2", log1.size() > 2 ? log1[2] : -1, 16000);

        // clamp: 50000 stored as 43999
        do_reset();
        clear_logs();
        wr(0, 50000);
        repeat (3) wait_tick();
        step(20);
        check("clamp_s0", log0.size() > 0 ? log0[0] : -1, 0);
        check("clamp_s1", log0.size() > 1 ? log0[1] : -1, 43999);
        check("clamp_s2", log0.size() > 2 ? log0[2] : -1, 43998);

        // overrun: hold busy for 3000 cycles after the first send
        do_reset();
        clear_logs();
        wait_tick();
        wait_send();
        dac_busy = 1'b1;
        step(1);
        n0 = n_sends;
        step(3000);
        check("no_send_while_busy", n_sends - n0, 0);
        check("overrun_set", overrun, 1);
        dac_busy = 1'b0;
        wait_send();
        check("resume_ch1", dac_data, 24'h320000);
        step(10);

        // error flag on ch1
        wr(1, 1001);
        wait_tick();
        step(1);
`ifdef MULTI_OSC_ERR_EN
        check("err_ch1", err_out, 2'b10);
`else
        check("err_off", err_out, 2'b00);
`endif
        step(20);

        // reset during WAIT of ch0
        wait_tick();
        wait_send();
        dac_busy = 1'b1;
        step(4);
        reset    = 1'b1;
        dac_busy = 1'b0;
        step(2);
        reset    = 1'b0;
        step(1);
        check("rst_mid_data", dac_data, 24'h0);
        check("rst_mid_send", dac_send, 0);
        check("rst_mid_ovr", overrun, 0);
        check("rst_mid_err", err_out, 0);
        wait_tick();
        tick_at = last_tick;
        wait_send();
        step(1);
        check("post_rst_latency", last_send - tick_at, 2);
        check("post_rst_data", dac_data, 24'h310000);
        step(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
